// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with programmable terminal value,
// parallel load, enable and a clock-enable prescaler. Emits single-cycle
// ovf/unf/tick pulses aligned with the count value they describe.
// Optional feature macro: MOD_COUNTER_CAPTURE_EN adds a capture input and a
// cap_val output that snapshots the pre-update count.
module mod_counter #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   dir,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  load_val,
  input  logic [DATA_WIDTH-1:0]  max_val,
  input  logic [PRESC_WIDTH-1:0] div,
`ifdef MOD_COUNTER_CAPTURE_EN
  input  logic                   capture,
  output logic [DATA_WIDTH-1:0]  cap_val,
`endif
  output logic [DATA_WIDTH-1:0]  count,
  output logic                   ovf,
  output logic                   unf,
  output logic                   tick
);

  localparam logic [DATA_WIDTH-1:0]  CNT_ONE   = DATA_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  count_reg, count_next;
  logic [PRESC_WIDTH-1:0] presc_reg, presc_next;
  logic                   ovf_reg, ovf_next;
  logic                   unf_reg, unf_next;
  logic                   tick_reg, tick_next;
  logic [DATA_WIDTH-1:0]  load_clamped;
  logic                   step;

  // Counter step qualifier: one step every div+1 enabled cycles.
  assign step = en && (presc_reg == div);

  // Loads never place the counter outside 0..max_val.
  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  // Next-state computation: load beats step, step beats hold.
  always_comb begin
    count_next = count_reg;
    presc_next = presc_reg;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    tick_next  = 1'b0;
    if (load) begin
      count_next = load_clamped;
      presc_next = '0;
    end else begin
      if (en) begin
        presc_next = step ? '0 : (presc_reg + PRESC_ONE);
      end
      if (step) begin
        tick_next = 1'b1;
        if (dir) begin
          // >= also catches a count left above a freshly lowered max_val.
          if (count_reg >= max_val) begin
            count_next = '0;
            ovf_next   = 1'b1;
          end else begin
            count_next = count_reg + CNT_ONE;
          end
        end else begin
          if (count_reg == '0) begin
            count_next = max_val;
            unf_next   = 1'b1;
          end else begin
            count_next = count_reg - CNT_ONE;
          end
        end
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      presc_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      presc_reg <= presc_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
      tick_reg  <= tick_next;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;
  assign unf   = unf_reg;
  assign tick  = tick_reg;

`ifdef MOD_COUNTER_CAPTURE_EN
  logic [DATA_WIDTH-1:0] cap_reg;

  // Snapshot of the count as it stood before this edge, independent of en/load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_reg <= '0;
    end else if (capture) begin
      cap_reg <= count_reg;
    end
  end

  assign cap_val = cap_reg;
`endif

endmodule
